// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset/bubble constants, PC helpers.
package mips_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // One fetched instruction together with its address.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  // Word-align an address by clearing the byte offset.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched {pc, ins} while RD is stalled.
module fetch_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ins,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] ins
);

  fetch_entry_t ent;

  // Flush beats load beats drain; load with drain replaces the entry.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ent <= '0;
    end else if (load) begin
      ent.valid <= 1'b1;
      ent.pc    <= in_pc;
      ent.ins   <= in_ins;
    end else if (drain) begin
      ent.valid <= 1'b0;
    end
  end

  assign valid = ent.valid;
  assign pc    = ent.pc;
  assign ins   = ent.ins;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC generation, single-outstanding imem
// handshake, RD pipeline register with skid buffer and delay-slot redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        Stall_RD,
  input  logic        Redirect_EX,
  input  logic [31:0] RedirectPC_EX,
  output logic [31:0] INS_RD,
  output logic [31:0] PC_RD,
  output logic        Valid_RD
);

  logic [1:0]  state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] drain_addr;   // address of the abandoned request while draining
  logic        comp;         // handshake completes this edge
  logic        good;         // completion whose data is kept
  logic        from_skid;    // RD takes the skid entry this edge
  logic        skid_load;
  logic        skid_nxt_valid;
  logic        skid_valid;
  logic [31:0] skid_pc, skid_ins;

  assign imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
  assign imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;

  assign comp      = imem_req & imem_ack;
  assign good      = comp & (state == ST_REQ) & ~Redirect_EX;
  // A redirect kills the wrong-path skid entry, so it must not reach RD.
  assign from_skid = ~Stall_RD & skid_valid & ~Redirect_EX;
  // Kept word parks in skid when RD is frozen or RD is busy taking skid.
  assign skid_load = good & (Stall_RD | skid_valid);
  assign skid_nxt_valid = ~Redirect_EX & (skid_load | (skid_valid & ~from_skid));

  fetch_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .drain  (from_skid),
    .flush  (Redirect_EX),
    .in_pc  (fetch_pc),
    .in_ins (imem_data),
    .valid  (skid_valid),
    .pc     (skid_pc),
    .ins    (skid_ins)
  );

  // Next-state: issue while skid has room, drain an abandoned request on redirect.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!skid_valid) state_nxt = ST_REQ;
      ST_REQ: begin
        if (comp)             state_nxt = (!Redirect_EX && skid_nxt_valid) ? ST_IDLE : ST_REQ;
        else if (Redirect_EX) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (comp) state_nxt = ST_REQ;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM, fetch PC (redirect beats increment) and drain address capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (Redirect_EX)  fetch_pc <= align_pc(RedirectPC_EX);
      else if (good)    fetch_pc <= fetch_pc + PC_STEP;
      if ((state == ST_REQ) && Redirect_EX && !comp) drain_addr <= fetch_pc;
    end
  end

  // RD register: skid first, then fresh word, else bubble; frozen on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      INS_RD   <= NOP_WORD;
      PC_RD    <= RESET_PC;
      Valid_RD <= 1'b0;
    end else if (!Stall_RD) begin
      if (from_skid) begin
        INS_RD   <= skid_ins;
        PC_RD    <= skid_pc;
        Valid_RD <= 1'b1;
      end else if (good) begin
        INS_RD   <= imem_data;
        PC_RD    <= fetch_pc;
        Valid_RD <= 1'b1;
      end else begin
        INS_RD   <= NOP_WORD;
        Valid_RD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream ordering model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic        Stall_RD = 1'b0;
  logic        Redirect_EX = 1'b0;
  logic [31:0] RedirectPC_EX = 32'h0;
  logic [31:0] INS_RD, PC_RD;
  logic        Valid_RD;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .Stall_RD(Stall_RD),
    .Redirect_EX(Redirect_EX), .RedirectPC_EX(RedirectPC_EX),
    .INS_RD(INS_RD), .PC_RD(PC_RD), .Valid_RD(Valid_RD)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; Stall_RD = 1'b0; Redirect_EX = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b1; Stall_RD = 1'b0; Redirect_EX = 1'b1;
    RedirectPC_EX = 32'h0000_0440;
    repeat (2) @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || INS_RD !== NOP ||
        PC_RD !== 32'h0 || Valid_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got req=%b addr=%h ins=%h pc=%h v=%b exp 0/0/0/0/0",
               imem_req, imem_addr, INS_RD, PC_RD, Valid_RD);
    end
    Redirect_EX = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    imem_ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
        n_fail++;
        $display("FAIL stream_addr k=%0d: got req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, 32'(4 * (k - 1)));
      end
      n_chk++;
      if (k == 1) begin
        if (Valid_RD !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_first_bubble: got v=%b exp 0", Valid_RD);
        end
      end else if (Valid_RD !== 1'b1 || PC_RD !== 32'(4 * (k - 2)) || INS_RD !== mem_word(32'(4 * (k - 2)))) begin
        n_fail++;
        $display("FAIL stream_rd k=%0d: got v=%b pc=%h ins=%h exp 1/%h/%h", k, Valid_RD, PC_RD, INS_RD,
                 32'(4 * (k - 2)), mem_word(32'(4 * (k - 2))));
      end
    end
  endtask

  task automatic test_ack_delay();
    logic [31:0] ea [9] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd12, 32'd16, 32'd20};
    logic        ev [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ep [9] = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd8, 32'd12, 32'd16};
    int waits = 0;
    do_reset();
    imem_ack = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== ea[k]) begin
        n_fail++;
        $display("FAIL ackdly_addr k=%0d: got req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, ea[k]);
      end
      n_chk++;
      if (Valid_RD !== ev[k] || PC_RD !== ep[k] || INS_RD !== (ev[k] ? mem_word(ep[k]) : NOP)) begin
        n_fail++;
        $display("FAIL ackdly_rd k=%0d: got v=%b pc=%h ins=%h exp %b/%h", k, Valid_RD, PC_RD, INS_RD, ev[k], ep[k]);
      end
      if (imem_req && imem_addr == 32'd8 && waits < 3) begin
        imem_ack = 1'b0; waits++;
      end else imem_ack = 1'b1;
    end
  endtask

  task automatic test_stall();
    logic [31:0] got [$];
    do_reset();
    imem_ack = 1'b1;
    repeat (4) @(negedge clk);
    Stall_RD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (Valid_RD !== 1'b1 || PC_RD !== 32'd8 || INS_RD !== mem_word(32'd8) || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold k=%0d: got v=%b pc=%h req=%b exp 1/00000008/0", k, Valid_RD, PC_RD, imem_req);
      end
    end
    Stall_RD = 1'b0;
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      @(negedge clk);
      if (Valid_RD) begin
        got.push_back(PC_RD);
        n_chk++;
        if (INS_RD !== mem_word(PC_RD)) begin
          n_fail++;
          $display("FAIL stall_ins: got %h exp %h", INS_RD, mem_word(PC_RD));
        end
      end
    end
    n_chk++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL stall_timeout: got %0d deliveries exp 3", got.size());
    end else if (got[0] !== 32'd12 || got[1] !== 32'd16 || got[2] !== 32'd20) begin
      n_fail++;
      $display("FAIL stall_order: got %h %h %h exp 0000000c 00000010 00000014", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    imem_ack = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (imem_addr !== 32'h1C || PC_RD !== 32'h18 || Valid_RD !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_setup: got addr=%h pc=%h v=%b exp 1c/18/1", imem_addr, PC_RD, Valid_RD);
    end
    imem_ack = 1'b0; Redirect_EX = 1'b1; RedirectPC_EX = 32'h0000_0100; Stall_RD = 1'b1;
    @(negedge clk);
    Redirect_EX = 1'b0; Stall_RD = 1'b0;
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1C || Valid_RD !== 1'b1 ||
        PC_RD !== 32'h18 || INS_RD !== mem_word(32'h18)) begin
      n_fail++;
      $display("FAIL drain_delay_slot: got req=%b addr=%h v=%b pc=%h exp 1/1c/1/18", imem_req, imem_addr, Valid_RD, PC_RD);
    end
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1C || Valid_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold: got req=%b addr=%h v=%b exp 1/1c/0", imem_req, imem_addr, Valid_RD);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || Valid_RD !== 1'b0 || INS_RD !== NOP) begin
      n_fail++;
      $display("FAIL drain_discard: got req=%b addr=%h v=%b ins=%h exp 1/100/0/0", imem_req, imem_addr, Valid_RD, INS_RD);
    end
    @(negedge clk);
    n_chk++;
    if (Valid_RD !== 1'b1 || PC_RD !== 32'h100 || INS_RD !== mem_word(32'h100)) begin
      n_fail++;
      $display("FAIL drain_target: got v=%b pc=%h ins=%h exp 1/100/%h", Valid_RD, PC_RD, INS_RD, mem_word(32'h100));
    end
  endtask

  // Waits for the next valid delivery and checks it is the expected PC.
  task automatic test_redirect_skid();
    logic [31:0] tgt [2] = '{32'h0000_0202, 32'h0000_0300};
    for (int ph = 0; ph < 2; ph++) begin
      logic seen = 1'b0;
      do_reset();
      imem_ack = 1'b1;
      repeat (4) @(negedge clk);
      Stall_RD = 1'b1;
      if (ph == 1) begin
        Redirect_EX = 1'b1; RedirectPC_EX = tgt[ph];
      end
      @(negedge clk);
      if (ph == 0) begin
        n_chk++;
        if (imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL skid_full_noreq: got req=%b exp 0", imem_req);
        end
        Redirect_EX = 1'b1; RedirectPC_EX = tgt[ph];
        @(negedge clk);
      end
      Redirect_EX = 1'b0; Stall_RD = 1'b0;
      n_chk++;
      if (Valid_RD !== 1'b1 || PC_RD !== 32'd8) begin
        n_fail++;
        $display("FAIL skid_rd_held ph=%0d: got v=%b pc=%h exp 1/8", ph, Valid_RD, PC_RD);
      end
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (Valid_RD) begin
          seen = 1'b1;
          n_chk++;
          if (PC_RD !== (tgt[ph] & ~32'h3) || INS_RD !== mem_word(tgt[ph] & ~32'h3)) begin
            n_fail++;
            $display("FAIL skid_redirect ph=%0d: got pc=%h ins=%h exp %h", ph, PC_RD, INS_RD, tgt[ph] & ~32'h3);
          end
        end
      end
      if (!seen) begin
        n_chk++; n_fail++;
        $display("FAIL skid_redirect_timeout ph=%0d: got no delivery exp one", ph);
      end
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    imem_ack = 1'b0; Redirect_EX = 1'b1; RedirectPC_EX = 32'h0000_0400;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL rstdrain_setup: got req=%b addr=%h exp 1/10", imem_req, imem_addr);
    end
    Redirect_EX = 1'b0; imem_ack = 1'b1; reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || INS_RD !== NOP || PC_RD !== 32'h0 || Valid_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL rstdrain_reset: got req=%b addr=%h ins=%h pc=%h v=%b exp all 0",
               imem_req, imem_addr, INS_RD, PC_RD, Valid_RD);
    end
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || Valid_RD !== 1'b0) begin
      n_fail++;
      $display("FAIL rstdrain_restart: got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, Valid_RD);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if (Valid_RD !== 1'b1 || PC_RD !== 32'(4 * k) || INS_RD !== mem_word(32'(4 * k))) begin
        n_fail++;
        $display("FAIL rstdrain_stream k=%0d: got v=%b pc=%h ins=%h exp 1/%h", k, Valid_RD, PC_RD, INS_RD, 32'(4 * k));
      end
    end
  endtask

  // Random traffic; model = expected next PC of the instruction stream plus
  // the RD contents it has accepted so far.
  task automatic test_random();
    logic [31:0] exp_next = 32'h0;
    logic [31:0] m_pc = 32'h0, m_ins = NOP;
    logic        m_v = 1'b0;
    logic        p_req = 1'b0, p_ack = 1'b0, s_stall = 1'b0, s_redir = 1'b0;
    logic [31:0] p_addr = 32'h0, s_tgt = 32'h0;
    int idle = 0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (p_req && !p_ack) begin
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
          n_fail++;
          $display("FAIL rand_addr_stable cyc=%0d: got req=%b addr=%h exp 1/%h", cyc, imem_req, imem_addr, p_addr);
        end
      end
      n_chk++;
      if (imem_req && imem_addr[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL rand_align cyc=%0d: got addr=%h exp aligned", cyc, imem_addr);
      end
      n_chk++;
      if (s_stall) begin
        if (Valid_RD !== m_v || PC_RD !== m_pc || INS_RD !== m_ins) begin
          n_fail++;
          $display("FAIL rand_stall_hold cyc=%0d: got %b/%h/%h exp %b/%h/%h", cyc, Valid_RD, PC_RD, INS_RD, m_v, m_pc, m_ins);
        end
      end else if (Valid_RD === 1'b1 && !s_redir) begin
        if (PC_RD !== exp_next || INS_RD !== mem_word(exp_next)) begin
          n_fail++;
          $display("FAIL rand_order cyc=%0d: got pc=%h ins=%h exp %h/%h", cyc, PC_RD, INS_RD, exp_next, mem_word(exp_next));
        end
        m_v = 1'b1; m_pc = exp_next; m_ins = mem_word(exp_next);
        exp_next = exp_next + 32'd4;
        idle = 0;
      end else begin
        if (Valid_RD !== 1'b0 || INS_RD !== NOP || PC_RD !== m_pc) begin
          n_fail++;
          $display("FAIL rand_bubble cyc=%0d: got v=%b pc=%h ins=%h exp 0/%h/0", cyc, Valid_RD, PC_RD, INS_RD, m_pc);
        end
        m_v = 1'b0; m_ins = NOP;
      end
      if (s_redir) exp_next = s_tgt & ~32'h3;
      if (!(Valid_RD && !s_stall)) idle++;
      if (idle > 300) begin
        n_chk++; n_fail++;
        $display("FAIL rand_liveness cyc=%0d: got %0d idle cycles exp <=300", cyc, idle);
        break;
      end
      p_req = imem_req; p_addr = imem_addr;
      imem_ack = ($urandom_range(99) < 60);
      Stall_RD = ($urandom_range(99) < 25);
      Redirect_EX = ($urandom_range(99) < 4);
      case ($urandom_range(2))
        0:       RedirectPC_EX = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
        1:       RedirectPC_EX = $urandom & 32'h0000_0FFF;
        default: RedirectPC_EX = $urandom;
      endcase
      p_ack = imem_ack; s_stall = Stall_RD; s_redir = Redirect_EX; s_tgt = RedirectPC_EX;
    end
    Stall_RD = 1'b0; Redirect_EX = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ack_delay();
    test_stall();
    test_redirect_drain();
    test_redirect_skid();
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
